// File: rtl/fetch_aligner_pkg.sv
// fetch_aligner_pkg: shared encodings and helpers for the RV32IC fetch aligner
package fetch_aligner_pkg;
  localparam logic [1:0] QUAD_32 = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != QUAD_32;
  endfunction
endpackage

// File: rtl/fetch_aligner_hw_queue.sv
// hw_queue: DEPTH-entry halfword circular buffer, push/pop of 0..2 halfwords per cycle
// ports: clk, rst, clr (sync clear); push_n/push_lo/push_hi (push_lo lands first);
//        pop_n; count (occupancy), h0/h1 (oldest two entries)
module hw_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [1:0]               push_n,
  input  logic [15:0]              push_lo,
  input  logic [15:0]              push_hi,
  input  logic [1:0]               pop_n,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              h0,
  output logic [15:0]              h1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [15:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign h0 = mem[rd];
  assign h1 = mem[rd + 1'b1];
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr] <= push_lo;
    if (push_n == 2'd2) mem[wr + 1'b1] <= push_hi;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      assert (int'(count) + int'(push_n) - int'(pop_n) <= DEPTH && int'(pop_n) <= int'(count));
      wr <= wr + PW'(push_n);
      rd <= rd + PW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: buffered RV32IC fetch unit reassembling 16/32-bit instructions from word fetches
// ports: clk_i, rst_i; Mem* = word-aligned request/response channel to I-memory;
//        Redirect_i/RedirectPC_i = flush and restart; Inst* = instruction to decode, Compressed_o = 16-bit
module fetch_aligner import fetch_aligner_pkg::*; #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC),
  parameter int            DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          MemReq_o,
  output logic [AW-1:0] MemAddr_o,
  input  logic          MemReady_i,
  input  logic          MemRvalid_i,
  input  logic [31:0]   MemRdata_i,
  input  logic          Redirect_i,
  input  logic [AW-1:0] RedirectPC_i,
  output logic          InstValid_o,
  input  logic          InstReady_i,
  output logic [31:0]   Inst_o,
  output logic [AW-1:0] InstPC_o,
  output logic          Compressed_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state;
  logic [AW-1:0] fetch_addr, head_pc, tgt_word;
  logic drop, skip, comp, fire, take_resp;
  logic [CW-1:0] count;
  logic [15:0] h0, h1;
  logic [1:0] push_n, pop_n;
  assign tgt_word = RedirectPC_i & ~AW'(3);
  assign comp = is_compressed(h0);
  assign InstValid_o = (count != '0 && comp) || count >= CW'(2);
  assign Inst_o = !InstValid_o ? 32'b0 : comp ? {16'b0, h0} : {h1, h0};
  assign Compressed_o = InstValid_o && comp;
  assign InstPC_o = head_pc;
  assign fire = InstValid_o && InstReady_i && !Redirect_i;
  assign pop_n = !fire ? 2'd0 : comp ? 2'd1 : 2'd2;
  // a response counts only while outstanding, not flushed, and not stale
  assign take_resp = state == WAIT && MemRvalid_i && !Redirect_i && !drop;
  assign push_n = !take_resp ? 2'd0 : skip ? 2'd1 : 2'd2;
  hw_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk_i),
    .rst(rst_i),
    .clr(Redirect_i),
    .push_n(push_n),
    .push_lo(skip ? MemRdata_i[31:16] : MemRdata_i[15:0]),
    .push_hi(MemRdata_i[31:16]),
    .pop_n(pop_n),
    .count(count),
    .h0(h0),
    .h1(h1)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      MemReq_o <= 1'b0;
      MemAddr_o <= RESET_PC & ~AW'(3);
      fetch_addr <= RESET_PC & ~AW'(3);
      head_pc <= RESET_PC;
      drop <= 1'b0;
      skip <= RESET_PC[1];
    end else begin
      case (state)
        // a redirect empties the buffer, so it may issue at once regardless of count
        IDLE: if (Redirect_i || count <= CW'(DEPTH - 2)) begin
          state <= REQ;
          MemReq_o <= 1'b1;
          MemAddr_o <= Redirect_i ? tgt_word : fetch_addr;
        end
        REQ: if (MemReady_i) begin
          state <= WAIT;
          MemReq_o <= 1'b0;
        end
        WAIT: if (MemRvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      // a stale (to-be-dropped) request must not advance the redirected fetch address
      fetch_addr <= Redirect_i ? tgt_word : (state == REQ && MemReady_i && !drop) ? MemAddr_o + AW'(4) : fetch_addr;
      head_pc <= Redirect_i ? RedirectPC_i & ~AW'(1) : fire ? head_pc + (comp ? AW'(2) : AW'(4)) : head_pc;
      drop <= Redirect_i ? (state == REQ || (state == WAIT && !MemRvalid_i)) : (state == WAIT && MemRvalid_i) ? 1'b0 : drop;
      skip <= Redirect_i ? RedirectPC_i[1] : take_resp ? 1'b0 : skip;
    end
  end
endmodule
